// File: rtl/traf_req.sv
// traf_req: request front-end for the traffic controller.
// Three identical channels (MS walk, SS walk, left-turn loop) each run
// raw input -> 2-flop synchronizer -> saturating debounce -> call FSM.
// Each call is held while ARMED. It is withdrawn when the controller's lamp
// shows the phase being served, or when the hold timer runs out.
module traf_req #(
    parameter int DB_CYCLES = 3,
    parameter int HOLD_MAX  = 60,
    parameter int CNT_W     = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MS,
    input  logic       BTN_SS,
    input  logic       LOOP_TURN,
    input  logic       WALK_MAIN,
    input  logic       WALK_SIDE,
    input  logic [4:0] MAIN_1,
    output logic       WALK_MS_SENSOR,
    output logic       WALK_SS_SENSOR,
    output logic       TURN_SENSOR,
    output logic [2:0] CALL_DROP
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        SERVING = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] DB_MAX    = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
    localparam int               TURN_CH   = 2;

    // Channel order everywhere is {TURN, SS, MS}.
    logic [2:0]       raw;
    logic [2:0]       svc;
    logic [2:0]       sync_p0;
    logic [2:0]       sync_p1;
    logic [CNT_W-1:0] db_cnt [3];
    logic [2:0]       db_level;
    logic [2:0]       db_prev;
    logic [2:0]       press;
    state_t           state      [3];
    state_t           state_next [3];
    logic [CNT_W-1:0] hold_cnt   [3];
    logic [CNT_W-1:0] hold_next  [3];
    logic [2:0]       sensor;
    logic [2:0]       sensor_next;
    logic [2:0]       drop;
    logic             unused_main;

    assign raw = {LOOP_TURN, BTN_SS, BTN_MS};
    assign svc = {MAIN_1[4], WALK_SIDE, WALK_MAIN};

    // Only the left-turn arrow of the main-north lamp vector matters here.
    assign unused_main = ^MAIN_1[3:0];

    // Stage p0/p1: synchronize the asynchronous raw inputs, then debounce
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            db_prev <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                db_cnt[ch] <= '0;
            end
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            db_prev <= db_level;
            for (int ch = 0; ch < 3; ch++) begin
                if (!sync_p1[ch]) begin
                    db_cnt[ch] <= '0;
                end else if (db_cnt[ch] != DB_MAX) begin
                    db_cnt[ch] <= db_cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

    // Debounced level and its rising edge (the press event)
    always_comb begin
        db_level = '0;
        press    = '0;
        for (int ch = 0; ch < 3; ch++) begin
            db_level[ch] = (db_cnt[ch] == DB_MAX);
            press[ch]    = db_level[ch] & ~db_prev[ch];
        end
    end

    // Per-channel call FSM: next state, hold counter and timeout pulse
    always_comb begin
        sensor_next = '0;
        drop        = '0;
        for (int ch = 0; ch < 3; ch++) begin
            state_next[ch] = state[ch];
            hold_next[ch]  = hold_cnt[ch];
            case (state[ch])
                IDLE: begin
                    // The service indicator is ignored until the call is armed.
                    if (press[ch]) begin
                        state_next[ch] = ARMED;
                        hold_next[ch]  = '0;
                    end
                end
                ARMED: begin
                    if (svc[ch]) begin
                        state_next[ch] = SERVING;
                    end else if (hold_cnt[ch] == HOLD_LAST) begin
                        state_next[ch] = IDLE;
                        drop[ch]       = 1'b1;
                    end else if (ch == TURN_CH && !db_level[ch]) begin
                        // Vehicle left the loop: cancel silently.
                        state_next[ch] = IDLE;
                    end else begin
                        hold_next[ch] = hold_cnt[ch] + CNT_W'(1);
                    end
                end
                SERVING: begin
                    if (!svc[ch]) begin
                        state_next[ch] = IDLE;
                    end
                end
                default: begin
                    state_next[ch] = IDLE;
                end
            endcase
            sensor_next[ch] = (state_next[ch] == ARMED);
        end
    end

    // Stage p2: state, hold counters and registered call outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            sensor <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                state[ch]    <= IDLE;
                hold_cnt[ch] <= '0;
            end
        end else begin
            sensor <= sensor_next;
            for (int ch = 0; ch < 3; ch++) begin
                state[ch]    <= state_next[ch];
                hold_cnt[ch] <= hold_next[ch];
            end
        end
    end

    assign WALK_MS_SENSOR = sensor[0];
    assign WALK_SS_SENSOR = sensor[1];
    assign TURN_SENSOR    = sensor[2];
    assign CALL_DROP      = drop;

endmodule

// File: tb/tb_traf_req.sv
// tb_traf_req: scenario bench for traf_req. Each scenario fills a stimulus
// queue and an expected-output queue cycle by cycle, then replays the
// stimulus and pops and compares one expected entry after every clock edge.
module tb_traf_req;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_ms = 1'b0;
    logic       btn_ss = 1'b0;
    logic       loop_turn = 1'b0;
    logic       walk_main = 1'b0;
    logic       walk_side = 1'b0;
    logic [4:0] main_1 = 5'b00000;
    logic       walk_ms_sensor;
    logic       walk_ss_sensor;
    logic       turn_sensor;
    logic [2:0] call_drop;
    logic [2:0] sens_obs;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       rst;
        logic       ms;
        logic       ss;
        logic       lp;
        logic       wm;
        logic       ws;
        logic [4:0] m1;
    } stim_t;

    typedef struct packed {
        logic [2:0] sens;
        logic [2:0] drop;
    } exp_t;

    stim_t stq[$];
    exp_t  sb[$];

    traf_req dut (
        .CLK            (clk),
        .RST            (rst),
        .BTN_MS         (btn_ms),
        .BTN_SS         (btn_ss),
        .LOOP_TURN      (loop_turn),
        .WALK_MAIN      (walk_main),
        .WALK_SIDE      (walk_side),
        .MAIN_1         (main_1),
        .WALK_MS_SENSOR (walk_ms_sensor),
        .WALK_SS_SENSOR (walk_ss_sensor),
        .TURN_SENSOR    (turn_sensor),
        .CALL_DROP      (call_drop)
    );

    assign sens_obs = {turn_sensor, walk_ss_sensor, walk_ms_sensor};

    always #5 clk = ~clk;

    task automatic apply(input stim_t s);
        rst       = s.rst;
        btn_ms    = s.ms;
        btn_ss    = s.ss;
        loop_turn = s.lp;
        walk_main = s.wm;
        walk_side = s.ws;
        main_1    = s.m1;
    endtask

    task automatic do_reset();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        apply(s);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Reset with all inputs high, then all three sensors rise together
    task automatic test_reset();
        stim_t s;
        exp_t  e;
        int    k;
        for (int i = 0; i < 9; i++) begin
            s = '0;
            s.rst = (i == 0);
            s.ms = 1'b1; s.ss = 1'b1; s.lp = 1'b1;
            stq.push_back(s);
            e.sens = (i >= 6) ? 3'b111 : 3'b000;
            e.drop = 3'b000;
            sb.push_back(e);
        end
        k = 0;
        while (sb.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (sens_obs !== e.sens) begin
                bad++;
                $display("FAIL reset_sensors k=%0d got=%b want=%b", k, sens_obs, e.sens);
            end
            total++;
            if (call_drop !== e.drop) begin
                bad++;
                $display("FAIL reset_drop k=%0d got=%b want=%b", k, call_drop, e.drop);
            end
            k++;
        end
    endtask

    // Two-sample glitch is rejected; three-sample press arms, then served
    task automatic test_debounce();
        stim_t s;
        exp_t  e;
        int    k;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            s = '0;
            s.ms = (i <= 1) || (i >= 12 && i <= 14);
            s.wm = (i == 20) || (i == 21);
            stq.push_back(s);
            e.sens = (i >= 17 && i < 20) ? 3'b001 : 3'b000;
            e.drop = 3'b000;
            sb.push_back(e);
        end
        k = 0;
        while (sb.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (sens_obs !== e.sens) begin
                bad++;
                $display("FAIL debounce_sensors k=%0d got=%b want=%b", k, sens_obs, e.sens);
            end
            total++;
            if (call_drop !== e.drop) begin
                bad++;
                $display("FAIL debounce_drop k=%0d got=%b want=%b", k, call_drop, e.drop);
            end
            k++;
        end
    endtask

    // SS served 10 cycles after arming; held button never re-arms
    task automatic test_service();
        stim_t s;
        exp_t  e;
        int    k;
        do_reset();
        for (int i = 0; i < 47; i++) begin
            s = '0;
            s.ss = (i <= 30) || (i >= 37);
            s.ws = (i >= 15 && i <= 19);
            stq.push_back(s);
            e.sens = ((i >= 5 && i < 15) || i >= 42) ? 3'b010 : 3'b000;
            e.drop = 3'b000;
            sb.push_back(e);
        end
        k = 0;
        while (sb.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (sens_obs !== e.sens) begin
                bad++;
                $display("FAIL service_sensors k=%0d got=%b want=%b", k, sens_obs, e.sens);
            end
            total++;
            if (call_drop !== e.drop) begin
                bad++;
                $display("FAIL service_drop k=%0d got=%b want=%b", k, call_drop, e.drop);
            end
            k++;
        end
    endtask

    // MS unserved: high for 60 cycles, drop pulse in the last one
    task automatic test_timeout();
        stim_t s;
        exp_t  e;
        int    k;
        do_reset();
        for (int i = 0; i < 68; i++) begin
            s = '0;
            s.ms = 1'b1;
            stq.push_back(s);
            e.sens = (i >= 5 && i <= 64) ? 3'b001 : 3'b000;
            e.drop = (i == 64) ? 3'b001 : 3'b000;
            sb.push_back(e);
        end
        k = 0;
        while (sb.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (sens_obs !== e.sens) begin
                bad++;
                $display("FAIL timeout_sensors k=%0d got=%b want=%b", k, sens_obs, e.sens);
            end
            total++;
            if (call_drop !== e.drop) begin
                bad++;
                $display("FAIL timeout_drop k=%0d got=%b want=%b", k, call_drop, e.drop);
            end
            k++;
        end
    endtask

    // Turn call cancelled by vehicle leaving, then a new call served by arrow
    task automatic test_turn();
        stim_t s;
        exp_t  e;
        int    k;
        do_reset();
        for (int i = 0; i < 36; i++) begin
            s = '0;
            s.lp = (i <= 9) || (i >= 16);
            s.m1 = (i >= 24 && i <= 27) ? 5'b10000 : 5'b00000;
            stq.push_back(s);
            e.sens = ((i >= 5 && i <= 12) || (i >= 21 && i < 24)) ? 3'b100 : 3'b000;
            e.drop = 3'b000;
            sb.push_back(e);
        end
        k = 0;
        while (sb.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (sens_obs !== e.sens) begin
                bad++;
                $display("FAIL turn_sensors k=%0d got=%b want=%b", k, sens_obs, e.sens);
            end
            total++;
            if (call_drop !== e.drop) begin
                bad++;
                $display("FAIL turn_drop k=%0d got=%b want=%b", k, call_drop, e.drop);
            end
            k++;
        end
    endtask

    // All channels armed together, reset mid-ARMED, then held inputs re-debounce
    task automatic test_concurrent();
        stim_t s;
        exp_t  e;
        int    k;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s = '0;
            s.rst = (i == 8);
            s.ms = 1'b1; s.ss = 1'b1; s.lp = 1'b1;
            stq.push_back(s);
            e.sens = ((i >= 5 && i <= 7) || i >= 14) ? 3'b111 : 3'b000;
            e.drop = 3'b000;
            sb.push_back(e);
        end
        k = 0;
        while (sb.size() > 0) begin
            apply(stq.pop_front());
            @(posedge clk);
            #1;
            e = sb.pop_front();
            total++;
            if (sens_obs !== e.sens) begin
                bad++;
                $display("FAIL concurrent_sensors k=%0d got=%b want=%b", k, sens_obs, e.sens);
            end
            total++;
            if (call_drop !== e.drop) begin
                bad++;
                $display("FAIL concurrent_drop k=%0d got=%b want=%b", k, call_drop, e.drop);
            end
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_service();
        test_timeout();
        test_turn();
        test_concurrent();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
